cbus_arbiter: RTL and testbench

- Multi-master arbiter between the per-port bus converters (instruction side and data side) and the single external cache bus.
- Replaces the stock cache-bus multiplexer at the top level.
- Grants one master at a time and holds the grant for a whole burst, from the first request beat until the response beat with last set.
- Forwards the granted master's request to the output and routes the bus response back to that master only.

---
 rtl/cbus_arbiter.sv | 73 +++++++
 tb/tb_cbus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: burst-holding round-robin or fixed-priority arbiter from several masters onto one cache bus
typedef struct packed {
  logic        valid;
  logic        is_write;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [3:0]  strobe;
  logic [31:0] data;
  logic [7:0]  len;
} cbus_req_t;

typedef struct packed {
  logic        ready;
  logic        last;
  logic [31:0] data;
} cbus_resp_t;

module cbus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  ireqs  [NUM_MASTERS],
  output cbus_resp_t iresps [NUM_MASTERS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);
  localparam int SW = $clog2(NUM_MASTERS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        r_state, w_next_state;
  logic [SW-1:0] r_sel, r_rr, w_next_sel, w_next_rr, w_base, w_win;
  logic          w_any, w_done;
  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int k);
    int t;
    t = int'(base) + k;
    return SW'(t >= NUM_MASTERS ? t - NUM_MASTERS : t);
  endfunction
  always_comb begin
    w_base = ROUND_ROBIN ? r_rr : '0;
    w_any  = 1'b0;
    w_win  = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (ireqs[wrap_add(w_base, k)].valid) begin
        w_any = 1'b1;
        w_win = wrap_add(w_base, k);
      end
    end
  end
  assign w_done = (r_state == BUSY) && oresp.ready && oresp.last;
  always_comb begin
    w_next_state = (r_state == IDLE) ? (w_any ? BUSY : IDLE) : (w_done ? IDLE : BUSY);
    w_next_sel   = (r_state == IDLE && w_any) ? w_win : r_sel;
    w_next_rr    = (ROUND_ROBIN && w_done) ? wrap_add(r_sel, 1) : r_rr;
    oreq         = '0;
    for (int j = 0; j < NUM_MASTERS; j++) iresps[j] = '0;
    if (r_state == BUSY) begin
      oreq          = ireqs[r_sel];
      iresps[r_sel] = oresp;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_next_state;
      r_sel   <= w_next_sel;
      r_rr    <= w_next_rr;
    end
  end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed and random checks of both arbitration modes against a transaction-level model
module tb_cbus_arbiter;
  localparam int N = 2;
  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  cbus_req_t  ireqs [N];
  cbus_resp_t oresp;
  cbus_req_t  oreq_rr, oreq_fp;
  cbus_resp_t iresps_rr [N];
  cbus_resp_t iresps_fp [N];
  int checks = 0;
  int failures = 0;
  bit m_busy [2];
  int m_sel [2];
  int m_rr [2];
  bit rec = 1'b0;
  bit prev_v [2];
  int q_rr [$];
  int q_fp [$];

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_MASTERS(N), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps_rr), .oreq(oreq_rr), .oresp(oresp));
  cbus_arbiter #(.NUM_MASTERS(N), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps_fp), .oreq(oreq_fp), .oresp(oresp));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic cbus_req_t mk(input logic w, input logic [31:0] a, input logic [3:0] s,
                                   input logic [31:0] dt, input logic [7:0] l);
    cbus_req_t r;
    r = '0;
    r.valid = 1'b1;
    r.is_write = w;
    r.size = 3'd2;
    r.addr = a;
    r.strobe = s;
    r.data = dt;
    r.len = l;
    return r;
  endfunction

  function automatic cbus_resp_t rsp(input logic rd, input logic ls, input logic [31:0] dt);
    cbus_resp_t r;
    r.ready = rd;
    r.last = ls;
    r.data = dt;
    return r;
  endfunction

  // winner = valid master at the smallest circular distance from the pointer
  function automatic int winner(input int base);
    int best;
    int bd;
    best = -1;
    bd = N;
    for (int i = 0; i < N; i++)
      if (ireqs[i].valid && ((i - base + N) % N) < bd) begin
        bd = (i - base + N) % N;
        best = i;
      end
    return best;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_sel[d] = 0;
      m_rr[d] = 0;
    end
  endtask

  task automatic model_edge();
    int w;
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        m_busy[d] = 1'b0;
        m_sel[d] = 0;
        m_rr[d] = 0;
      end else if (!m_busy[d]) begin
        w = winner(d == 0 ? m_rr[d] : 0);
        if (w >= 0) begin
          m_busy[d] = 1'b1;
          m_sel[d] = w;
        end
      end else if (oresp.ready && oresp.last) begin
        m_busy[d] = 1'b0;
        if (d == 0) m_rr[d] = (m_sel[d] + 1) % N;
      end
    end
  endtask

  task automatic check_outputs();
    cbus_req_t er;
    cbus_resp_t ep;
    for (int d = 0; d < 2; d++) begin
      er = m_busy[d] ? ireqs[m_sel[d]] : '0;
      chk(d ? "model_oreq_fp" : "model_oreq_rr", 128'(d ? oreq_fp : oreq_rr), 128'(er));
      for (int j = 0; j < N; j++) begin
        ep = (m_busy[d] && m_sel[d] == j) ? oresp : '0;
        chk(d ? "model_iresp_fp" : "model_iresp_rr", 128'(d ? iresps_fp[j] : iresps_rr[j]), 128'(ep));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    if (rec) begin
      if (oreq_rr.valid && !prev_v[0]) q_rr.push_back(oreq_rr.addr == ireqs[0].addr ? 0 : 1);
      if (oreq_fp.valid && !prev_v[1]) q_fp.push_back(oreq_fp.addr == ireqs[0].addr ? 0 : 1);
    end
    prev_v[0] = oreq_rr.valid;
    prev_v[1] = oreq_fp.valid;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ireqs[0] = '0;
    ireqs[1] = '0;
    oresp = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clr();
    model_reset();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    clr();
    model_reset();
    #1 resetn = 1'b0;
    #1;
    chk("rst_oreq_rr", 128'(oreq_rr), 128'(0));
    chk("rst_oreq_fp", 128'(oreq_fp), 128'(0));
    chk("rst_iresp0", 128'(iresps_rr[0]), 128'(0));
    chk("rst_iresp1", 128'(iresps_rr[1]), 128'(0));
    do_reset();
    // single master read
    ireqs[0] = mk(1'b0, 32'h1fc0_0000, 4'hf, 32'h0, 8'd0);
    tick();
    chk("t1_valid", 128'(oreq_rr.valid), 128'(1));
    chk("t1_addr", 128'(oreq_rr.addr), 128'(32'h1fc0_0000));
    tick();
    tick();
    oresp = rsp(1'b1, 1'b1, 32'hdeadbeef);
    #1;
    chk("t1_ready", 128'(iresps_rr[0].ready), 128'(1));
    chk("t1_data", 128'(iresps_rr[0].data), 128'(32'hdeadbeef));
    tick();
    clr();
    #1;
    chk("t1_idle", 128'(oreq_rr.valid), 128'(0));
    // simultaneous requests
    do_reset();
    ireqs[0] = mk(1'b0, 32'h100, 4'hf, 32'h0, 8'd0);
    ireqs[1] = mk(1'b0, 32'h200, 4'hf, 32'h0, 8'd0);
    tick();
    chk("t2_first", 128'(oreq_rr.addr), 128'(32'h100));
    oresp = rsp(1'b1, 1'b1, 32'h11);
    #1;
    chk("t2_loser_resp", 128'(iresps_rr[1]), 128'(0));
    chk("t2_winner_ready", 128'(iresps_rr[0].ready), 128'(1));
    tick();
    ireqs[0] = '0;
    oresp = '0;
    #1;
    chk("t2_bubble", 128'(oreq_rr.valid), 128'(0));
    tick();
    chk("t2_second", 128'(oreq_rr.addr), 128'(32'h200));
    oresp = rsp(1'b1, 1'b1, 32'h22);
    tick();
    clr();
    // burst hold
    ireqs[1] = mk(1'b0, 32'h300, 4'hf, 32'h0, 8'd3);
    tick();
    chk("t3_grant", 128'(oreq_rr.addr), 128'(32'h300));
    oresp = rsp(1'b1, 1'b0, 32'h1);
    tick();
    ireqs[0] = mk(1'b0, 32'h400, 4'hf, 32'h0, 8'd0);
    oresp = rsp(1'b1, 1'b0, 32'h2);
    #1;
    chk("t3_hold_b2", 128'(oreq_rr), 128'(ireqs[1]));
    chk("t3_m0_wait", 128'(iresps_rr[0].ready), 128'(0));
    tick();
    oresp = rsp(1'b1, 1'b0, 32'h3);
    tick();
    oresp = rsp(1'b1, 1'b1, 32'h4);
    #1;
    chk("t3_hold_b4", 128'(oreq_rr.addr), 128'(32'h300));
    tick();
    ireqs[1] = '0;
    oresp = '0;
    #1;
    chk("t3_bubble", 128'(oreq_rr.valid), 128'(0));
    tick();
    chk("t3_m0_grant", 128'(oreq_rr.addr), 128'(32'h400));
    oresp = rsp(1'b1, 1'b1, 32'h5);
    tick();
    clr();
    // fairness in both modes
    do_reset();
    ireqs[0] = mk(1'b0, 32'ha0, 4'hf, 32'h0, 8'd0);
    ireqs[1] = mk(1'b0, 32'hb0, 4'hf, 32'h0, 8'd0);
    oresp = rsp(1'b1, 1'b1, 32'h0);
    rec = 1'b1;
    repeat (13) tick();
    rec = 1'b0;
    chk("t4_rr_count", 128'(q_rr.size() >= 6), 128'(1));
    chk("t4_fp_count", 128'(q_fp.size() >= 6), 128'(1));
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t4_rr_order%0d", k), 128'(q_rr[k]), 128'(k % 2));
      chk($sformatf("t4_fp_order%0d", k), 128'(q_fp[k]), 128'(0));
    end
    // write pass-through
    do_reset();
    ireqs[1] = mk(1'b1, 32'h8000_0010, 4'b0011, 32'h1234_5678, 8'd0);
    tick();
    chk("t5_req", 128'(oreq_rr), 128'(ireqs[1]));
    chk("t5_strobe", 128'(oreq_rr.strobe), 128'(4'b0011));
    chk("t5_data", 128'(oreq_rr.data), 128'(32'h1234_5678));
    chk("t5_write", 128'(oreq_rr.is_write), 128'(1));
    oresp = rsp(1'b1, 1'b1, 32'h0);
    #1;
    chk("t5_last", 128'(iresps_rr[1].last), 128'(1));
    tick();
    clr();
    // reset mid-burst
    do_reset();
    ireqs[0] = mk(1'b0, 32'h600, 4'hf, 32'h0, 8'd3);
    tick();
    oresp = rsp(1'b1, 1'b0, 32'h1);
    tick();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    chk("t6_rr_valid", 128'(oreq_rr.valid), 128'(0));
    chk("t6_fp_valid", 128'(oreq_fp.valid), 128'(0));
    chk("t6_iresp0", 128'(iresps_rr[0]), 128'(0));
    chk("t6_iresp1", 128'(iresps_rr[1]), 128'(0));
    clr();
    tick();
    resetn = 1'b1;
    ireqs[1] = mk(1'b0, 32'h700, 4'hf, 32'h0, 8'd0);
    tick();
    chk("t6_regrant_valid", 128'(oreq_rr.valid), 128'(1));
    chk("t6_regrant_addr", 128'(oreq_rr.addr), 128'(32'h700));
    oresp = rsp(1'b1, 1'b1, 32'h0);
    tick();
    clr();
    // random traffic against the model
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        ireqs[i].valid = ($urandom_range(0, 9) < 7);
        ireqs[i].is_write = 1'($urandom);
        ireqs[i].size = 3'($urandom);
        ireqs[i].addr = $urandom;
        ireqs[i].strobe = 4'($urandom);
        ireqs[i].data = $urandom;
        ireqs[i].len = 8'($urandom);
      end
      oresp = rsp(1'($urandom), 1'($urandom), $urandom);
      tick();
    end
    clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
